// File: rtl/dmem_pkg.sv
// Shared encodings for the data-memory controller: access sizes, FSM states, byte-lane bit ranges.
// No logic; pure constants and types.
// Imported by dmem_lane_align and dmem_ctrl.
package dmem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int BYTE0_LSB = 0;
    localparam int BYTE0_MSB = 7;
    localparam int BYTE1_LSB = 8;
    localparam int BYTE1_MSB = 15;
    localparam int BYTE2_LSB = 16;
    localparam int BYTE2_MSB = 23;
    localparam int BYTE3_LSB = 24;
    localparam int BYTE3_MSB = 31;

    function automatic logic [31:0] ext8(input logic [7:0] b, input logic zext);
        return zext ? {24'h0, b} : {{24{b[7]}}, b};
    endfunction

    function automatic logic [31:0] ext16(input logic [15:0] h, input logic zext);
        return zext ? {16'h0, h} : {{16{h[15]}}, h};
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering: store strobes + replicated write word, load extract/extend, misalign/error flags.
// Combinational, zero latency; no handshake. DMEM_MISALIGN_ERR_EN turns misalignment into an error,
// otherwise low address bits are forced to the access alignment.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        ld_unsigned,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wr_dat,
    input  logic [31:0] rd_word,
    output logic [3:0]  wr_strb,
    output logic [31:0] wr_word,
    output logic [31:0] ld_dat,
    output logic        misaligned,
    output logic        err
);

    logic [1:0]  lane;
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    assign misaligned = ((size == SZ_HALF) && addr_lo[0]) ||
                        ((size == SZ_WORD) && (addr_lo != 2'b00));

`ifdef DMEM_MISALIGN_ERR_EN
    assign err = (size == SZ_RSVD) || misaligned;
`else
    assign err = (size == SZ_RSVD);
`endif

    // Forcing alignment is harmless in the error build: errored accesses never write or return data.
    always_comb begin
        lane = addr_lo;
        case (size)
            SZ_HALF: lane = {addr_lo[1], 1'b0};
            SZ_WORD: lane = 2'b00;
            default: lane = addr_lo;
        endcase
    end

    always_comb begin
        sel_byte = rd_word[BYTE0_MSB:BYTE0_LSB];
        case (lane)
            2'd1:    sel_byte = rd_word[BYTE1_MSB:BYTE1_LSB];
            2'd2:    sel_byte = rd_word[BYTE2_MSB:BYTE2_LSB];
            2'd3:    sel_byte = rd_word[BYTE3_MSB:BYTE3_LSB];
            default: sel_byte = rd_word[BYTE0_MSB:BYTE0_LSB];
        endcase
        sel_half = lane[1] ? rd_word[BYTE3_MSB:BYTE2_LSB] : rd_word[BYTE1_MSB:BYTE0_LSB];
    end

    always_comb begin
        wr_strb = 4'b0000;
        wr_word = 32'h0;
        ld_dat  = 32'h0;
        if (!err) begin
            case (size)
                SZ_BYTE: begin
                    wr_strb = 4'b0001 << lane;
                    wr_word = {4{wr_dat[7:0]}};
                    ld_dat  = ext8(sel_byte, ld_unsigned);
                end
                SZ_HALF: begin
                    wr_strb = lane[1] ? 4'b1100 : 4'b0011;
                    wr_word = {2{wr_dat[15:0]}};
                    ld_dat  = ext16(sel_half, ld_unsigned);
                end
                SZ_WORD: begin
                    wr_strb = 4'b1111;
                    wr_word = wr_dat;
                    ld_dat  = rd_word;
                end
                default: begin
                    wr_strb = 4'b0000;
                    wr_word = 32'h0;
                    ld_dat  = 32'h0;
                end
            endcase
        end
    end

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller for the MEM stage: byte/half/word loads and stores, one request outstanding.
// Latency: stores/errors respond 1 cycle after accept, loads RD_LATENCY cycles after accept.
// Backpressure: req_ready only in IDLE; response held stable until rsp_ready. DMEM_MISALIGN_ERR_EN selects misalign errors.
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DEPTH      = 64,
    parameter int RD_LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err
);

    localparam int IDX_W    = $clog2(DEPTH);
    localparam int CNT_W    = (RD_LATENCY > 2) ? $clog2(RD_LATENCY - 1) : 1;
    localparam int LAT_INIT = (RD_LATENCY > 1) ? (RD_LATENCY - 2) : 0;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       mem [DEPTH];
    logic [IDX_W-1:0]  idx;
    logic              acc_vld;
    logic              wr_vld;
    logic [3:0]        wr_strb;
    logic [31:0]       wr_word;
    logic [31:0]       rd_word;
    logic [31:0]       ld_dat;
    logic              lane_misaligned;
    logic              lane_err;
    logic              unused_addr_bits;

    assign idx              = req_addr[2 +: IDX_W];
    assign unused_addr_bits = ^{req_addr[ADDR_W-1:IDX_W+2], lane_misaligned};

    assign req_ready = (state_q == IDLE) && rst_n;
    assign acc_vld   = req_valid && req_ready;
    assign wr_vld    = acc_vld && req_we;
    assign rsp_valid = (state_q == RESP);
    assign rd_word   = mem[idx];

    dmem_lane_align u_lane_align (
        .size        (req_size),
        .ld_unsigned (req_unsigned),
        .addr_lo     (req_addr[1:0]),
        .wr_dat      (req_wdata),
        .rd_word     (rd_word),
        .wr_strb     (wr_strb),
        .wr_word     (wr_word),
        .ld_dat      (ld_dat),
        .misaligned  (lane_misaligned),
        .err         (lane_err)
    );

    // Array is deliberately not reset; errored stores arrive with an all-zero strobe.
    always_ff @(posedge clk) begin
        if (wr_vld) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_strb[b]) begin
                    mem[idx][8*b +: 8] <= wr_word[8*b +: 8];
                end
            end
        end
    end

    // Load data is sampled at accept so a later store can never leak into an in-flight load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_rdata <= 32'h0;
            rsp_err   <= 1'b0;
        end else if (acc_vld) begin
            rsp_rdata <= req_we ? 32'h0 : ld_dat;
            rsp_err   <= lane_err;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (acc_vld) begin
                    if (req_we || lane_err || (RD_LATENCY == 1)) begin
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_W'(LAT_INIT);
                    end
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Randomized self-checking bench for dmem_ctrl against a word-array reference model.
// Honours DMEM_MISALIGN_ERR_EN so the same bench covers both builds.
module tb_dmem_ctrl;
    import dmem_pkg::*;

    localparam int LAT = 3;
    localparam int WORDS = 64;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_we, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_rdata;

    int          n_chk = 0;
    int          n_fail = 0;
    logic [31:0] mdl [WORDS];

    always #5 clk = ~clk;

    dmem_ctrl #(.ADDR_W(32), .DEPTH(WORDS), .RD_LATENCY(LAT)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit mdl_err(input logic [1:0] size, input logic [31:0] addr);
        if (size == 2'd3) return 1'b1;
`ifdef DMEM_MISALIGN_ERR_EN
        if (size == 2'd1 && (addr % 2) != 0) return 1'b1;
        if (size == 2'd2 && (addr % 4) != 0) return 1'b1;
`endif
        return 1'b0;
    endfunction

    function automatic int mdl_off(input logic [1:0] size, input logic [31:0] addr);
        if (size == 2'd0) return int'(addr % 4);
        if (size == 2'd1) return int'((addr % 4) / 2) * 2;
        return 0;
    endfunction

    function automatic logic [31:0] mdl_mask(input logic [1:0] size);
        if (size == 2'd0) return 32'hFF;
        if (size == 2'd1) return 32'hFFFF;
        return 32'hFFFF_FFFF;
    endfunction

    function automatic logic [31:0] mdl_load(input logic [1:0] size, input logic uns, input logic [31:0] addr);
        logic [31:0] v;
        if (mdl_err(size, addr)) return 32'h0;
        v = (mdl[int'((addr / 4) % WORDS)] >> (8 * mdl_off(size, addr))) & mdl_mask(size);
        if (!uns && size == 2'd0 && v >= 32'h80)   v = v | 32'hFFFF_FF00;
        if (!uns && size == 2'd1 && v >= 32'h8000) v = v | 32'hFFFF_0000;
        return v;
    endfunction

    task automatic mdl_store(input logic [1:0] size, input logic [31:0] addr, input logic [31:0] wdata);
        int w;
        int sh;
        if (mdl_err(size, addr)) return;
        w  = int'((addr / 4) % WORDS);
        sh = 8 * mdl_off(size, addr);
        mdl[w] = (mdl[w] & ~(mdl_mask(size) << sh)) | ((wdata & mdl_mask(size)) << sh);
    endtask

    // Waits for req_ready at a negedge, presents the request, and lets it be accepted at the next posedge.
    task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata);
        int g = 0;
        while (!req_ready && g < 20) begin
            @(negedge clk);
            g++;
        end
        req_we = we; req_size = size; req_unsigned = uns; req_addr = addr; req_wdata = wdata;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata, input int stall,
                          output logic [31:0] rd, output logic er);
        logic [31:0] exp_d;
        logic        exp_e;
        int          k = 0;
        exp_e = mdl_err(size, addr);
        exp_d = we ? 32'h0 : mdl_load(size, uns, addr);
        issue(we, size, uns, addr, wdata);
        if (we) mdl_store(size, addr, wdata);
        do begin
            @(negedge clk);
            k++;
        end while (!rsp_valid && k < 20);
        chk("rsp_valid", {31'b0, rsp_valid}, 32'd1);
        chk("latency", 32'(k), (we || exp_e) ? 32'd1 : 32'(LAT));
        chk("rdata", rsp_rdata, exp_d);
        chk("err", {31'b0, rsp_err}, {31'b0, exp_e});
        rd = rsp_rdata;
        er = rsp_err;
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            chk("hold_valid", {31'b0, rsp_valid}, 32'd1);
            chk("hold_rdata", rsp_rdata, exp_d);
            chk("hold_err", {31'b0, rsp_err}, {31'b0, exp_e});
            chk("hold_ready", {31'b0, req_ready}, 32'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        @(negedge clk);
        chk("idle_valid", {31'b0, rsp_valid}, 32'd0);
        chk("idle_ready", {31'b0, req_ready}, 32'd1);
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        logic [31:0] a;
        logic [1:0]  sz;
        int          r;

        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
        req_addr = 32'h0; req_wdata = 32'h0; rsp_ready = 1'b0;
        for (int i = 0; i < WORDS; i++) mdl[i] = 32'h0;

        repeat (3) @(negedge clk);
        chk("rst_req_ready", {31'b0, req_ready}, 32'd0);
        chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'h0);
        chk("rst_rsp_err", {31'b0, rsp_err}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", {31'b0, req_ready}, 32'd1);

        for (int w = 0; w < WORDS; w++) do_req(1'b1, SZ_WORD, 1'b0, 32'(w * 4), $urandom, 0, rd, er);

        do_req(1'b1, SZ_WORD, 1'b0, 32'h08, 32'hDEAD_BEEF, 0, rd, er);
        do_req(1'b0, SZ_BYTE, 1'b0, 32'h09, 32'h0, 0, rd, er);  chk("lb_09", rd, 32'hFFFF_FFBE);
        do_req(1'b0, SZ_BYTE, 1'b1, 32'h09, 32'h0, 0, rd, er);  chk("lbu_09", rd, 32'h0000_00BE);
        do_req(1'b0, SZ_HALF, 1'b0, 32'h0A, 32'h0, 0, rd, er);  chk("lh_0a", rd, 32'hFFFF_DEAD);
        do_req(1'b0, SZ_HALF, 1'b1, 32'h0A, 32'h0, 0, rd, er);  chk("lhu_0a", rd, 32'h0000_DEAD);
        do_req(1'b1, SZ_BYTE, 1'b0, 32'h0B, 32'h12, 0, rd, er);
        do_req(1'b0, SZ_WORD, 1'b0, 32'h08, 32'h0, 0, rd, er);  chk("lw_after_sb", rd, 32'h12AD_BEEF);
        do_req(1'b1, SZ_HALF, 1'b0, 32'h08, 32'h5566, 0, rd, er);
        do_req(1'b0, SZ_WORD, 1'b0, 32'h08, 32'h0, 5, rd, er);  chk("lw_after_sh", rd, 32'h12AD_5566);

        do_req(1'b0, SZ_WORD, 1'b0, 32'h06, 32'h0, 0, rd, er);
`ifdef DMEM_MISALIGN_ERR_EN
        chk("lw_06_err", {31'b0, er}, 32'd1);
        chk("lw_06_rdata", rd, 32'h0);
        do_req(1'b1, SZ_HALF, 1'b0, 32'h09, 32'hAAAA, 0, rd, er);
        do_req(1'b0, SZ_WORD, 1'b0, 32'h08, 32'h0, 0, rd, er);  chk("sh_09_untouched", rd, 32'h12AD_5566);
`else
        chk("lw_06_err", {31'b0, er}, 32'd0);
        chk("lw_06_rdata", rd, mdl[1]);
`endif
        do_req(1'b0, SZ_RSVD, 1'b0, 32'h10, 32'h0, 0, rd, er);  chk("rsvd_ld_err", {31'b0, er}, 32'd1);
        do_req(1'b1, SZ_RSVD, 1'b0, 32'h10, 32'hFFFF_FFFF, 0, rd, er);
        chk("rsvd_st_err", {31'b0, er}, 32'd1);

        // Reset while a load waits: response must vanish.
        issue(1'b0, SZ_WORD, 1'b0, 32'h08, 32'h0);
        @(negedge clk);
        rst_n = 1'b0;
        #1 chk("wait_rst_valid", {31'b0, rsp_valid}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("wait_rst_no_rsp", {31'b0, rsp_valid}, 32'd0);
        end
        chk("wait_rst_rdata", rsp_rdata, 32'h0);

        // Store accepted, reset during its response: write stays, response is dropped.
        issue(1'b1, SZ_WORD, 1'b0, 32'h20, 32'hCAFE_F00D);
        mdl_store(SZ_WORD, 32'h20, 32'hCAFE_F00D);
        @(negedge clk);
        chk("st_rsp_before_rst", {31'b0, rsp_valid}, 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("st_rst_no_rsp", {31'b0, rsp_valid}, 32'd0);
        end
        do_req(1'b0, SZ_WORD, 1'b0, 32'h20, 32'h0, 0, rd, er);  chk("st_survives_rst", rd, 32'hCAFE_F00D);

        for (int n = 0; n < 300; n++) begin
            r  = $urandom_range(0, 9);
            sz = (r < 3) ? SZ_BYTE : (r < 6) ? SZ_HALF : (r < 9) ? SZ_WORD : SZ_RSVD;
            a  = $urandom;
            do_req(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom,
                   $urandom_range(0, 2), rd, er);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
